// File: rtl/phy_rx_deframer_pkg.sv
// Purpose : shared definitions for the receive deframer (state encoding, default symbols).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Ports   : none. Symbol defaults are 8-bit; wider builds override COM_SYM/IDLE_SYM.
package phy_rx_deframer_pkg;

  // Encoding shared with the TX side; keep the values fixed.
  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } rx_state_e;

  localparam logic [7:0] DEF_COM_SYM  = 8'hBC;
  localparam logic [7:0] DEF_IDLE_SYM = 8'h7C;

  // Counter width for values 0..n-1, never below one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phy_rx_deframer_align.sv
// Purpose : serial-to-word shifter with bit counter and post-reset fill gating.
// Latency : word is combinational from the current serial bit; counters update next edge.
// Backpressure: none, one bit consumed every clk.
// Ports   : i_clk/i_reset (sync, active-high), i_serial bit in, i_realign restarts the
//           bit counter; o_word current word, o_word_ok once WIDTH bits seen, o_boundary
//           on the last bit of an aligned word.
module phy_rx_deframer_align
  import phy_rx_deframer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_serial,
  input  logic             i_realign,
  output logic [WIDTH-1:0] o_word,
  output logic             o_word_ok,
  output logic             o_boundary
);

  localparam int BW = cnt_w(WIDTH);

  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bit_cnt;
  logic [BW-1:0]    r_fill;

  // The word includes the bit on the wire this cycle, so a match is seen
  // on the same edge that captures the symbol's last bit.
  assign o_word     = {r_shift[WIDTH-2:0], i_serial};
  assign o_word_ok  = (r_fill == BW'(WIDTH - 1));
  assign o_boundary = (r_bit_cnt == BW'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_fill    <= '0;
    end else begin
      r_shift <= o_word;
      // Saturates at WIDTH-1: from then on the shift register is fully populated.
      if (!o_word_ok) r_fill <= r_fill + BW'(1);
      // After a realign the next bit is bit 0 of the following word.
      if (i_realign || o_boundary) r_bit_cnt <= '0;
      else                         r_bit_cnt <= r_bit_cnt + BW'(1);
    end
  end

endmodule

// File: rtl/phy_rx_deframer.sv
// Purpose : bit-align on COM_SYM, lock after SYNC_COUNT COMs, unstripe words onto LANES lanes.
// Latency : frame visible one clk after the last bit of lane LANES-1; frame_strobe pulses then.
// Backpressure: none, data_out/valid_out hold until the next frame overwrites them.
// Ports   : clk, reset (sync active-high), serial_in; data_out lane i at [i*WIDTH +: WIDTH],
//           valid_out per lane, frame_strobe, active_out; err_count when PHY_RX_ERRCNT_EN
//           is defined (COM in ACTIVE counted as error, lane marked invalid).
module phy_rx_deframer
  import phy_rx_deframer_pkg::*;
#(
  parameter int               LANES      = 4,
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COM_SYM    = WIDTH'(DEF_COM_SYM),
  parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(DEF_IDLE_SYM),
  parameter int               SYNC_COUNT = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   serial_in,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [LANES-1:0]       valid_out,
  output logic                   frame_strobe,
  output logic                   active_out
`ifdef PHY_RX_ERRCNT_EN
  ,output logic [15:0]           err_count
`endif
);

  localparam int LW = cnt_w(LANES);
  localparam int CW = cnt_w(SYNC_COUNT + 1);

  rx_state_e             r_state;
  rx_state_e             w_next_state;
  logic [CW-1:0]         r_com_cnt;
  logic [LW-1:0]         r_lane_idx;
  logic [LANES*WIDTH-1:0] r_buf;
  logic [LANES-1:0]      r_vbuf;

  logic [WIDTH-1:0]       w_word;
  logic                   w_word_ok;
  logic                   w_boundary;
  logic                   w_is_com;
  logic                   w_realign;
  logic                   w_com_hit;
  logic                   w_store;
  logic                   w_last;
  logic                   w_lane_vld;
  logic [LANES*WIDTH-1:0] w_frame_dat;
  logic [LANES-1:0]       w_frame_vld;

  phy_rx_deframer_align #(.WIDTH(WIDTH)) u_align (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_serial   (serial_in),
    .i_realign  (w_realign),
    .o_word     (w_word),
    .o_word_ok  (w_word_ok),
    .o_boundary (w_boundary)
  );

  assign w_is_com = (w_word == COM_SYM);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= SEARCH;
    else       r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      SEARCH: begin
        if (w_word_ok && w_is_com)
          w_next_state = (SYNC_COUNT == 1) ? ACTIVE : LOCKING;
      end
      LOCKING: begin
        if (w_boundary) begin
          if (!w_is_com)                              w_next_state = SEARCH;
          else if (r_com_cnt == CW'(SYNC_COUNT - 1))  w_next_state = ACTIVE;
        end
      end
      ACTIVE:  w_next_state = ACTIVE;
      default: w_next_state = SEARCH;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_realign  = (r_state == SEARCH) && w_word_ok && w_is_com;
    w_com_hit  = (r_state == LOCKING) && w_boundary && w_is_com;
    w_store    = (r_state == ACTIVE) && w_boundary;
    w_last     = w_store && (r_lane_idx == LW'(LANES - 1));
`ifdef PHY_RX_ERRCNT_EN
    w_lane_vld = (w_word != IDLE_SYM) && !w_is_com;
`else
    w_lane_vld = (w_word != IDLE_SYM);
`endif
    // The final lane comes straight from the shifter, it never lands in r_buf first.
    w_frame_dat = r_buf;
    w_frame_dat[(LANES-1)*WIDTH +: WIDTH] = w_word;
    w_frame_vld = r_vbuf;
    w_frame_vld[LANES-1] = w_lane_vld;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_com_cnt    <= '0;
      r_lane_idx   <= '0;
      r_buf        <= '0;
      r_vbuf       <= '0;
      data_out     <= '0;
      valid_out    <= '0;
      frame_strobe <= 1'b0;
      active_out   <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      active_out   <= (w_next_state == ACTIVE);

      if (w_realign)                                  r_com_cnt <= CW'(1);
      else if (w_com_hit)                             r_com_cnt <= r_com_cnt + CW'(1);
      else if ((r_state == LOCKING) && w_boundary)    r_com_cnt <= '0;

      if ((r_state != ACTIVE) && (w_next_state == ACTIVE))
        r_lane_idx <= '0;

      if (w_store) begin
        r_buf[r_lane_idx*WIDTH +: WIDTH] <= w_word;
        r_vbuf[r_lane_idx]               <= w_lane_vld;
        if (w_last) begin
          r_lane_idx   <= '0;
          data_out     <= w_frame_dat;
          valid_out    <= w_frame_vld;
          frame_strobe <= 1'b1;
        end else begin
          r_lane_idx <= r_lane_idx + LW'(1);
        end
      end
    end
  end

`ifdef PHY_RX_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      err_count <= '0;
    else if (w_store && w_is_com && (err_count != 16'hFFFF))
      err_count <= err_count + 16'd1;
  end
`endif

endmodule
